vtok_scanner: RTL and testbench

//  Hardware lexer stage that directly feeds the Verilog parser block. It takes a raw source byte stream
//  and strips whitespace and comments. It emits one classified token descriptor per token: kind, first byte,

---
 rtl/vtok_pkg.sv | 109 ++++++++++
 rtl/vtok_charclass.sv | 39 +++
 rtl/vtok_scanner.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_vtok_scanner.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vtok_pkg.sv
// Shared types and constants for the Verilog token scanner.
// Build option: define VTOK_COMMENT_TOKENS_EN to emit comments as TK_COMMENT
// descriptors; leave it undefined to drop comments silently.
package vtok_pkg;

`ifdef VTOK_COMMENT_TOKENS_EN
  localparam bit COMMENT_TOKENS_EN = 1'b1;
`else
  localparam bit COMMENT_TOKENS_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    TK_IDENT   = 3'd0,
    TK_ESCID   = 3'd1,
    TK_NUMBER  = 3'd2,
    TK_OP      = 3'd3,
    TK_STRING  = 3'd4,
    TK_DIR     = 3'd5,
    TK_COMMENT = 3'd6,
    TK_EOF     = 3'd7
  } tok_kind_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_IDENT,
    S_ESCID,
    S_NUM,
    S_DIR,
    S_STR,
    S_STR_BS,
    S_SLASH,
    S_LCMT,
    S_BCMT,
    S_BCMT_STAR
  } state_e;

  typedef enum logic [3:0] {
    CC_WS,      // space, TAB, CR
    CC_LF,      // line feed: whitespace that also ends a line comment
    CC_ALPHA,   // a-z A-Z _ $
    CC_DIGIT,   // 0-9
    CC_TICK,    // '
    CC_QMARK,   // ?
    CC_BSLASH,  // backslash
    CC_BTICK,   // `
    CC_DQUOTE,  // "
    CC_SLASH,   // /
    CC_STAR,    // *
    CC_OTHER
  } char_class_e;

  localparam logic [7:0] CH_SP     = 8'h20;
  localparam logic [7:0] CH_TAB    = 8'h09;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_US     = 8'h5F;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_TICK   = 8'h27;
  localparam logic [7:0] CH_QMARK  = 8'h3F;
  localparam logic [7:0] CH_BSLASH = 8'h5C;
  localparam logic [7:0] CH_BTICK  = 8'h60;
  localparam logic [7:0] CH_DQUOTE = 8'h22;
  localparam logic [7:0] CH_SLASH  = 8'h2F;
  localparam logic [7:0] CH_STAR   = 8'h2A;

  function automatic logic is_ws(input char_class_e c);
    return (c == CC_WS) || (c == CC_LF);
  endfunction

  function automatic logic is_id_start(input char_class_e c);
    return c == CC_ALPHA;
  endfunction

  function automatic logic is_id_cont(input char_class_e c);
    return (c == CC_ALPHA) || (c == CC_DIGIT);
  endfunction

  function automatic logic is_num_start(input char_class_e c);
    return (c == CC_DIGIT) || (c == CC_TICK);
  endfunction

  function automatic logic is_num_cont(input char_class_e c);
    return is_id_cont(c) || (c == CC_TICK) || (c == CC_QMARK);
  endfunction

  // Kind reported when the token held in state s is closed.
  function automatic tok_kind_e kind_of(input state_e s);
    case (s)
      S_IDENT:                       return TK_IDENT;
      S_ESCID:                       return TK_ESCID;
      S_NUM:                         return TK_NUMBER;
      S_DIR:                         return TK_DIR;
      S_STR, S_STR_BS:               return TK_STRING;
      S_SLASH:                       return TK_OP;
      S_LCMT, S_BCMT, S_BCMT_STAR:   return TK_COMMENT;
      default:                       return TK_IDENT;
    endcase
  endfunction

  // States whose partial token is illegal at end of stream.
  function automatic logic is_unterminated(input state_e s);
    return (s == S_STR) || (s == S_STR_BS) || (s == S_BCMT) || (s == S_BCMT_STAR);
  endfunction

  function automatic logic emit_allowed(input tok_kind_e k);
    return (k != TK_COMMENT) || COMMENT_TOKENS_EN;
  endfunction

endpackage

// File: rtl/vtok_charclass.sv
// Combinational byte classifier for the token scanner.
module vtok_charclass
  import vtok_pkg::*;
(
  input  logic [7:0]  byte_i,
  output char_class_e cls_o
);

  // Map one ASCII byte onto the scanner's character classes.
  always_comb begin
    // NOTE: default first so every path assigns cls_o and no latch is inferred.
    cls_o = CC_OTHER;
    if (byte_i == CH_LF) begin
      cls_o = CC_LF;
    end else if (byte_i == CH_SP || byte_i == CH_TAB || byte_i == CH_CR) begin
      cls_o = CC_WS;
    end else if ((byte_i >= 8'h61 && byte_i <= 8'h7A) || (byte_i >= 8'h41 && byte_i <= 8'h5A) ||
                 byte_i == CH_US || byte_i == CH_DOLLAR) begin
      cls_o = CC_ALPHA;
    end else if (byte_i >= 8'h30 && byte_i <= 8'h39) begin
      cls_o = CC_DIGIT;
    end else if (byte_i == CH_TICK) begin
      cls_o = CC_TICK;
    end else if (byte_i == CH_QMARK) begin
      cls_o = CC_QMARK;
    end else if (byte_i == CH_BSLASH) begin
      cls_o = CC_BSLASH;
    end else if (byte_i == CH_BTICK) begin
      cls_o = CC_BTICK;
    end else if (byte_i == CH_DQUOTE) begin
      cls_o = CC_DQUOTE;
    end else if (byte_i == CH_SLASH) begin
      cls_o = CC_SLASH;
    end else if (byte_i == CH_STAR) begin
      cls_o = CC_STAR;
    end
  end

endmodule

// File: rtl/vtok_scanner.sv
// Verilog lexer stage: raw byte stream in, classified token descriptors out.
// Whitespace is dropped; comments are dropped unless VTOK_COMMENT_TOKENS_EN
// is defined, in which case they are emitted as TK_COMMENT descriptors.
module vtok_scanner
  import vtok_pkg::*;
#(
  parameter int MAX_TOK_LEN = 64,
  parameter int OFS_W       = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [7:0]                         in_byte,
  input  logic                               in_last,
  output logic                               tok_valid,
  input  logic                               tok_ready,
  output tok_kind_e                          tok_kind,
  output logic [7:0]                         tok_char,
  output logic [$clog2(MAX_TOK_LEN+1)-1:0]   tok_len,
  output logic [OFS_W-1:0]                   tok_ofs,
  output logic                               tok_last,
  output logic                               err_overlong,
  output logic                               err_unterminated
);

  localparam int LEN_W = $clog2(MAX_TOK_LEN + 1);

  // Scanner state
  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [7:0]         char_q, char_d;
  logic [OFS_W-1:0]   sofs_q, sofs_d;     // offset of the open token's first byte
  logic [OFS_W-1:0]   ofs_q, ofs_d;       // count of accepted bytes
  logic               rep_vld_q, rep_vld_d;
  logic [7:0]         rep_byte_q, rep_byte_d;
  logic [OFS_W-1:0]   rep_ofs_q, rep_ofs_d;
  logic               rep_last_q, rep_last_d;
  logic               eof_pend_q, eof_pend_d;
  logic               eof_unt_q, eof_unt_d;

  // Output register
  logic               tok_valid_q, tok_valid_d;
  tok_kind_e          tok_kind_q, tok_kind_d;
  logic [7:0]         tok_char_q, tok_char_d;
  logic [LEN_W-1:0]   tok_len_q, tok_len_d;
  logic [OFS_W-1:0]   tok_ofs_q, tok_ofs_d;
  logic               tok_last_q, tok_last_d;
  logic               err_ovl_q, err_ovl_d;
  logic               err_unt_q, err_unt_d;

  // Byte under processing: the replayed terminator has priority over new input.
  logic               can_emit, acc, proc;
  logic [7:0]         byte_c;
  logic               last_c;
  logic [OFS_W-1:0]   bofs_c;
  char_class_e        cls_c;

  assign can_emit = !tok_valid_q || tok_ready;
  assign in_ready = !reset && can_emit && !rep_vld_q && !eof_pend_q;
  assign acc      = in_valid && in_ready;
  assign proc     = acc || (rep_vld_q && can_emit && !eof_pend_q);
  assign byte_c   = rep_vld_q ? rep_byte_q : in_byte;
  assign last_c   = rep_vld_q ? rep_last_q : in_last;
  assign bofs_c   = rep_vld_q ? rep_ofs_q  : ofs_q;

  vtok_charclass u_charclass (
    .byte_i (byte_c),
    .cls_o  (cls_c)
  );

  // Per-byte lexing decision, token emission and output register next state.
  always_comb begin
    state_e           state_n;
    state_e           tok_state;
    logic             add, close, term, op, fin, drop, emit, e_ovl, e_unt, e_last;
    logic [LEN_W-1:0] new_len;
    tok_kind_e        e_kind;
    logic [7:0]       e_char;
    logic [LEN_W-1:0] e_len;
    logic [OFS_W-1:0] e_ofs;

    state_d    = state_q;
    len_d      = len_q;
    char_d     = char_q;
    sofs_d     = sofs_q;
    ofs_d      = acc ? ofs_q + OFS_W'(1) : ofs_q;
    rep_vld_d  = rep_vld_q && !proc;
    rep_byte_d = rep_byte_q;
    rep_ofs_d  = rep_ofs_q;
    rep_last_d = rep_last_q;
    eof_pend_d = eof_pend_q;
    eof_unt_d  = eof_unt_q;

    state_n   = state_q;
    tok_state = state_q;
    add = 1'b0; close = 1'b0; term = 1'b0; op = 1'b0; fin = 1'b0; drop = 1'b0;
    new_len = len_q;
    emit = 1'b0; e_ovl = 1'b0; e_unt = 1'b0; e_last = 1'b0;
    e_kind = TK_IDENT; e_char = 8'h00; e_len = '0; e_ofs = '0;

    if (eof_pend_q) begin
      if (can_emit) begin
        emit       = 1'b1;
        e_kind     = TK_EOF;
        e_ofs      = ofs_q;
        e_last     = 1'b1;
        e_unt      = eof_unt_q;
        ofs_d      = '0;
        eof_pend_d = 1'b0;
        eof_unt_d  = 1'b0;
      end
    end else if (proc) begin
      case (state_q)
        S_IDLE: begin
          if (is_ws(cls_c))                 ;
          else if (is_id_start(cls_c))      begin state_n = S_IDENT; add = 1'b1; end
          else if (cls_c == CC_BSLASH)      begin state_n = S_ESCID; add = 1'b1; end
          else if (is_num_start(cls_c))     begin state_n = S_NUM;   add = 1'b1; end
          else if (cls_c == CC_BTICK)       begin state_n = S_DIR;   add = 1'b1; end
          else if (cls_c == CC_DQUOTE)      begin state_n = S_STR;   add = 1'b1; end
          else if (cls_c == CC_SLASH)       begin state_n = S_SLASH; add = 1'b1; end
          else                              op = 1'b1;
        end
        S_IDENT, S_DIR: begin
          if (is_id_cont(cls_c)) add  = 1'b1;
          else                   term = 1'b1;
        end
        S_NUM: begin
          if (is_num_cont(cls_c)) add  = 1'b1;
          else                    term = 1'b1;
        end
        S_ESCID: begin
          if (is_ws(cls_c)) term = 1'b1;
          else              add  = 1'b1;
        end
        S_STR: begin
          add = 1'b1;
          if (cls_c == CC_DQUOTE)      close   = 1'b1;
          else if (cls_c == CC_BSLASH) state_n = S_STR_BS;
        end
        S_STR_BS: begin
          add     = 1'b1;
          state_n = S_STR;
        end
        S_SLASH: begin
          if (cls_c == CC_SLASH)     begin state_n = S_LCMT; add = 1'b1; end
          else if (cls_c == CC_STAR) begin state_n = S_BCMT; add = 1'b1; end
          else                       term = 1'b1;
        end
        S_LCMT: begin
          if (cls_c == CC_LF) close = 1'b1;
          else                add   = 1'b1;
        end
        S_BCMT: begin
          add = 1'b1;
          if (cls_c == CC_STAR) state_n = S_BCMT_STAR;
        end
        S_BCMT_STAR: begin
          add = 1'b1;
          if (cls_c == CC_SLASH)      close   = 1'b1;
          else if (cls_c != CC_STAR)  state_n = S_BCMT;
        end
        default: state_n = S_IDLE;
      endcase

      new_len = add ? len_q + LEN_W'(1) : len_q;
      if (add && len_q == '0) begin
        char_d = byte_c;
        sofs_d = bofs_c;
      end

      // A terminator closes the token and is re-run from S_IDLE next cycle,
      // carrying its own offset and end-of-stream flag along.
      if (term) begin
        rep_vld_d  = 1'b1;
        rep_byte_d = byte_c;
        rep_ofs_d  = bofs_c;
        rep_last_d = last_c;
      end

      if (close || term) begin
        fin       = 1'b1;
        tok_state = state_q;
      end else if (last_c && state_n != S_IDLE) begin
        fin       = 1'b1;
        tok_state = state_n;
        drop      = is_unterminated(state_n);
      end

      if (last_c && !term) begin
        eof_pend_d = 1'b1;
        eof_unt_d  = drop;
      end

      if (op) begin
        emit   = 1'b1;
        e_kind = TK_OP;
        e_char = byte_c;
        e_len  = LEN_W'(1);
        e_ofs  = bofs_c;
      end else if (fin) begin
        state_d = S_IDLE;
        len_d   = '0;
        if (!drop && new_len != '0 && emit_allowed(kind_of(tok_state))) begin
          emit   = 1'b1;
          e_kind = kind_of(tok_state);
          e_char = char_d;
          e_len  = new_len;
          e_ofs  = sofs_d;
        end
      end else if (add && new_len == LEN_W'(MAX_TOK_LEN)) begin
        // Saturated: ship this piece and keep scanning the same kind.
        state_d = state_n;
        len_d   = '0;
        if (emit_allowed(kind_of(state_n))) begin
          emit   = 1'b1;
          e_kind = kind_of(state_n);
          e_char = char_d;
          e_len  = new_len;
          e_ofs  = sofs_d;
          e_ovl  = 1'b1;
        end
      end else begin
        state_d = state_n;
        len_d   = new_len;
      end
    end

    tok_valid_d = can_emit ? emit : tok_valid_q;
    tok_kind_d  = emit ? e_kind : tok_kind_q;
    tok_char_d  = emit ? e_char : tok_char_q;
    tok_len_d   = emit ? e_len  : tok_len_q;
    tok_ofs_d   = emit ? e_ofs  : tok_ofs_q;
    tok_last_d  = emit ? e_last : tok_last_q;
    err_ovl_d   = emit && e_ovl;
    err_unt_d   = emit && e_unt;
  end

  // Register scanner state and the output descriptor.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      char_q      <= 8'h00;
      sofs_q      <= '0;
      ofs_q       <= '0;
      rep_vld_q   <= 1'b0;
      rep_byte_q  <= 8'h00;
      rep_ofs_q   <= '0;
      rep_last_q  <= 1'b0;
      eof_pend_q  <= 1'b0;
      eof_unt_q   <= 1'b0;
      tok_valid_q <= 1'b0;
      tok_kind_q  <= TK_IDENT;
      tok_char_q  <= 8'h00;
      tok_len_q   <= '0;
      tok_ofs_q   <= '0;
      tok_last_q  <= 1'b0;
      err_ovl_q   <= 1'b0;
      err_unt_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q     <= state_d;
      len_q       <= len_d;
      char_q      <= char_d;
      sofs_q      <= sofs_d;
      ofs_q       <= ofs_d;
      rep_vld_q   <= rep_vld_d;
      rep_byte_q  <= rep_byte_d;
      rep_ofs_q   <= rep_ofs_d;
      rep_last_q  <= rep_last_d;
      eof_pend_q  <= eof_pend_d;
      eof_unt_q   <= eof_unt_d;
      tok_valid_q <= tok_valid_d;
      tok_kind_q  <= tok_kind_d;
      tok_char_q  <= tok_char_d;
      tok_len_q   <= tok_len_d;
      tok_ofs_q   <= tok_ofs_d;
      tok_last_q  <= tok_last_d;
      err_ovl_q   <= err_ovl_d;
      err_unt_q   <= err_unt_d;
    end
  end

  assign tok_valid        = tok_valid_q;
  assign tok_kind         = tok_kind_q;
  assign tok_char         = tok_char_q;
  assign tok_len          = tok_len_q;
  assign tok_ofs          = tok_ofs_q;
  assign tok_last         = tok_last_q;
  assign err_overlong     = err_ovl_q;
  assign err_unterminated = err_unt_q;

endmodule

// File: tb/tb_vtok_scanner.sv
// Directed self-checking bench for vtok_scanner.
module tb_vtok_scanner;
  import vtok_pkg::*;

  typedef struct packed {
    tok_kind_e   kind;
    logic [7:0]  ch;
    logic [6:0]  len;
    logic [15:0] ofs;
    logic        last;
    logic        ovl;
    logic        unt;
  } desc_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_byte;
  logic        in_last;
  logic        tok_valid;
  logic        tok_ready;
  tok_kind_e   tok_kind;
  logic [7:0]  tok_char;
  logic [6:0]  tok_len;
  logic [15:0] tok_ofs;
  logic        tok_last;
  logic        err_overlong;
  logic        err_unterminated;

  int    checks = 0;
  int    errors = 0;
  desc_t got_q[$];
  int    stall_viol = 0;
  bit    stall_mode = 1'b0;

  vtok_scanner #(.MAX_TOK_LEN(64), .OFS_W(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_byte          (in_byte),
    .in_last          (in_last),
    .tok_valid        (tok_valid),
    .tok_ready        (tok_ready),
    .tok_kind         (tok_kind),
    .tok_char         (tok_char),
    .tok_len          (tok_len),
    .tok_ofs          (tok_ofs),
    .tok_last         (tok_last),
    .err_overlong     (err_overlong),
    .err_unterminated (err_unterminated)
  );

  initial clk = 1'b0;
  initial forever #5 clk = ~clk;

  function automatic desc_t mk(input tok_kind_e k, input logic [7:0] c, input int l,
                               input int o, input bit la, input bit ov, input bit un);
    desc_t d;
    d.kind = k; d.ch = c; d.len = 7'(l); d.ofs = 16'(o);
    d.last = la; d.ovl = ov; d.unt = un;
    return d;
  endfunction

  function automatic string fmt(input desc_t d);
    return $sformatf("kind=%0d char=%02h len=%0d ofs=%0d last=%0b ovl=%0b unt=%0b",
                     d.kind, d.ch, d.len, d.ofs, d.last, d.ovl, d.unt);
  endfunction

  // Monitor: collect handshaken descriptors at mid-cycle and watch stall stability.
  initial begin
    desc_t cur, held;
    bit    stalled, ovl_seen, unt_seen;
    stalled = 0; ovl_seen = 0; unt_seen = 0; held = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stalled = 0; ovl_seen = 0; unt_seen = 0;
      end else begin
        cur = mk(tok_kind, tok_char, int'(tok_len), int'(tok_ofs), tok_last, 1'b0, 1'b0);
        if (stalled && (!tok_valid || cur !== held)) stall_viol++;
        if (err_overlong)     ovl_seen = 1;
        if (err_unterminated) unt_seen = 1;
        if (tok_valid && tok_ready) begin
          cur.ovl = ovl_seen; cur.unt = unt_seen;
          got_q.push_back(cur);
          ovl_seen = 0; unt_seen = 0;
        end
        stalled = tok_valid && !tok_ready;
        held = mk(tok_kind, tok_char, int'(tok_len), int'(tok_ofs), tok_last, 1'b0, 1'b0);
      end
    end
  end

  // Downstream ready: always 1, or random stalls of 1..10 cycles.
  initial begin
    int hold;
    hold = 0;
    tok_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (!stall_mode) begin
        tok_ready = 1'b1; hold = 0;
      end else if (hold > 0) begin
        tok_ready = 1'b0; hold--;
      end else if ($urandom_range(0, 2) == 0) begin
        tok_ready = 1'b0; hold = $urandom_range(0, 9);
      end else begin
        tok_ready = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last);
    bit ok;
    ok = 0;
    in_valid = 1'b1; in_byte = b; in_last = last;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send: byte %02h not accepted within 200 cycles", b);
    end
  endtask

  task automatic send_str(input string s, input bit last);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], last && (i == s.len() - 1));
  endtask

  task automatic wait_tokens(input string name, input int n);
    int c;
    c = 0;
    while (got_q.size() < n && c < 2000) begin
      @(posedge clk); c++;
    end
    #1;
    idle(20);
    checks++;
    if (got_q.size() !== n) begin
      errors++;
      $display("FAIL %s count: got %0d descriptors, expected %0d", name, got_q.size(), n);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; in_byte = 8'h00; in_last = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tok_valid, tok_char, tok_len, tok_ofs, tok_last, err_overlong, err_unterminated, in_ready} !== '0
        || tok_kind !== TK_IDENT) begin
      errors++;
      $display("FAIL reset_outputs: valid=%0b kind=%0d len=%0d ofs=%0d last=%0b ready=%0b, expected all 0",
               tok_valid, tok_kind, tok_len, tok_ofs, tok_last, in_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%0b expected 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    desc_t exp[$];
    got_q.delete();
    exp.push_back(mk(TK_IDENT,  "a",   1, 0, 0, 0, 0));
    exp.push_back(mk(TK_OP,     "=",   1, 1, 0, 0, 0));
    exp.push_back(mk(TK_IDENT,  "b",   1, 2, 0, 0, 0));
    exp.push_back(mk(TK_OP,     ";",   1, 3, 0, 0, 0));
    exp.push_back(mk(TK_EOF,    8'h00, 0, 4, 1, 0, 0));
    send_str("a=b;", 1);
    wait_tokens("basic", exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (got_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL basic[%0d]: got %s expected %s", i, fmt(got_q[i]), fmt(exp[i]));
      end
    end
  endtask

  task automatic test_comment;
    desc_t exp[$];
    got_q.delete();
    exp.push_back(mk(TK_NUMBER, 8'h27, 3, 0, 0, 0, 0));
    exp.push_back(mk(TK_OP,     ":",   1, 3, 0, 0, 0));
`ifdef VTOK_COMMENT_TOKENS_EN
    exp.push_back(mk(TK_COMMENT, "/",  3, 4, 0, 0, 0));
`endif
    exp.push_back(mk(TK_IDENT,  "t",   1, 9, 0, 0, 0));
    exp.push_back(mk(TK_EOF,    8'h00, 0, 10, 1, 0, 0));
    send_str("'h0://E\n t", 1);
    wait_tokens("comment", exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (got_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL comment[%0d]: got %s expected %s", i, fmt(got_q[i]), fmt(exp[i]));
      end
    end
  endtask

  task automatic test_escid;
    desc_t exp[$];
    got_q.delete();
    exp.push_back(mk(TK_ESCID,  8'h5C, 6, 0, 0, 0, 0));
    exp.push_back(mk(TK_OP,     "=",   1, 7, 0, 0, 0));
    exp.push_back(mk(TK_NUMBER, "1",   1, 9, 0, 0, 0));
    exp.push_back(mk(TK_EOF,    8'h00, 0, 10, 1, 0, 0));
    send_str("\\33esc = 1", 1);
    wait_tokens("escid", exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (got_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL escid[%0d]: got %s expected %s", i, fmt(got_q[i]), fmt(exp[i]));
      end
    end
  endtask

  task automatic test_slash_op;
    desc_t exp[$];
    got_q.delete();
    exp.push_back(mk(TK_IDENT, "x",   1, 0, 0, 0, 0));
    exp.push_back(mk(TK_OP,    "/",   1, 1, 0, 0, 0));
    exp.push_back(mk(TK_IDENT, "y",   1, 2, 0, 0, 0));
    exp.push_back(mk(TK_EOF,   8'h00, 0, 3, 1, 0, 0));
    send_str("x/y", 1);
    wait_tokens("slash_op", exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (got_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL slash_op[%0d]: got %s expected %s", i, fmt(got_q[i]), fmt(exp[i]));
      end
    end
  endtask

  task automatic test_string;
    desc_t exp[$];
    got_q.delete();
    // "a\"" : quote, a, backslash, quote, quote -> one 5-byte string
    exp.push_back(mk(TK_STRING, 8'h22, 5, 0, 0, 0, 0));
    exp.push_back(mk(TK_DIR,    8'h60, 2, 5, 0, 0, 0));
    exp.push_back(mk(TK_EOF,    8'h00, 0, 7, 1, 0, 0));
    send_str("\"a\\\"\"`d", 1);
    wait_tokens("string", exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (got_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL string[%0d]: got %s expected %s", i, fmt(got_q[i]), fmt(exp[i]));
      end
    end
  endtask

  task automatic test_back_to_back_stall;
    desc_t exp[$];
    got_q.delete();
    stall_viol = 0;
    stall_mode = 1'b1;
    exp.push_back(mk(TK_IDENT,  "a",   1, 0, 0, 0, 0));
    exp.push_back(mk(TK_OP,     "=",   1, 1, 0, 0, 0));
    exp.push_back(mk(TK_IDENT,  "b",   1, 2, 0, 0, 0));
    exp.push_back(mk(TK_OP,     ";",   1, 3, 0, 0, 0));
    exp.push_back(mk(TK_EOF,    8'h00, 0, 4, 1, 0, 0));
    send_str("a=b;", 1);
    wait_tokens("stall", exp.size());
    stall_mode = 1'b0;
    idle(2);
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (got_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL stall[%0d]: got %s expected %s", i, fmt(got_q[i]), fmt(exp[i]));
      end
    end
    checks++;
    if (stall_viol !== 0) begin
      errors++;
      $display("FAIL stall_stable: %0d cycles where tok_* changed while stalled, expected 0", stall_viol);
    end
  endtask

  task automatic test_overlong;
    desc_t exp[$];
    got_q.delete();
    exp.push_back(mk(TK_IDENT, 8'h61,            64, 0,  0, 1, 0));
    exp.push_back(mk(TK_IDENT, 8'(8'h61 + 64 % 26), 6, 64, 0, 0, 0));
    exp.push_back(mk(TK_EOF,   8'h00,             0, 70, 1, 0, 0));
    for (int i = 0; i < 70; i++) send_byte(8'(8'h61 + i % 26), i == 69);
    wait_tokens("overlong", exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (got_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL overlong[%0d]: got %s expected %s", i, fmt(got_q[i]), fmt(exp[i]));
      end
    end
  endtask

  task automatic test_unterminated;
    desc_t exp;
    got_q.delete();
    exp = mk(TK_EOF, 8'h00, 0, 4, 1, 0, 1);
    send_str("/* x", 1);
    wait_tokens("unterminated", 1);
    checks++;
    if (got_q[0] !== exp) begin
      errors++;
      $display("FAIL unterminated: got %s expected %s", fmt(got_q[0]), fmt(exp));
    end
  endtask

  task automatic test_reset_mid;
    desc_t exp[$];
    got_q.delete();
    send_str("abc", 0);
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(1);
    got_q.delete();
    idle(20);
    checks++;
    if (got_q.size() !== 0) begin
      errors++;
      $display("FAIL reset_mid_drop: got %0d descriptors after reset, expected 0", got_q.size());
    end
    exp.push_back(mk(TK_IDENT, "q",   1, 0, 0, 0, 0));
    exp.push_back(mk(TK_EOF,   8'h00, 0, 1, 1, 0, 0));
    send_str("q", 1);
    wait_tokens("reset_mid", exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (got_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL reset_mid[%0d]: got %s expected %s", i, fmt(got_q[i]), fmt(exp[i]));
      end
    end
  endtask

  initial begin
    in_valid = 1'b0; in_byte = 8'h00; in_last = 1'b0; reset = 1'b1;
    #1;
    test_reset();
    test_basic();
    test_comment();
    test_escid();
    test_slash_op();
    test_string();
    test_back_to_back_stall();
    test_overlong();
    test_unterminated();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
